vga_frame_buffer: RTL and testbench

- Parametrised frame buffer between the VGA timing generator and the RGB output stage.
- Stores BPP-bit pixels in an internal dual-port RAM and generates the read address with an incremental row counter, not a multiplier.
- Adds a valid/ready pixel write port, a hardware clear-screen engine, and a latency-aligned overlay mux for register displays.

---
 rtl/vga_fb_pkg.sv | 34 +++
 rtl/vga_fb_ram.sv | 28 ++
 rtl/vga_frame_buffer.sv | 169 ++++++++++++++++
 tb/tb_vga_frame_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the VGA frame buffer.
// Pixel colour expansion and FSM state encoding.
package vga_fb_pkg;

  localparam int LATENCY = 3;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } fb_state_e;

  function automatic bit bpp_legal(input int bpp);
    return (bpp == 3) || (bpp == 6) ||
           (bpp == 12) || (bpp == 24);
  endfunction

  // Channel bit i of the 8-bit output repeats source bit (i % cw).
  function automatic logic [23:0] expand_rgb(
    input logic [23:0] pix,
    input int          bpp
  );
    int          cw;
    logic [23:0] rgb;
    cw  = bpp / 3;
    rgb = '0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 8; i++) begin
        rgb[c*8+i] = pix[c*cw + (i % cw)];
      end
    end
    return rgb;
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port pixel RAM, synchronous read.
// A same-address read and write returns the old word.
module vga_fb_ram #(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_q <= mem[raddr];
  end

  assign rdata = rd_q;

endmodule

// File: rtl/vga_frame_buffer.sv
// Frame buffer: 3-stage display read, pixel write port,
// clear-screen engine and latency-aligned overlay mux.
module vga_frame_buffer
  import vga_fb_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int BPP      = 3,
  parameter int ADDR_W   = 19
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [10:0]    vga_h,
  input  logic [10:0]    vga_v,
  input  logic           ovl_on,
  input  logic [BPP-1:0] ovl_pixel,
  output logic [23:0]    pixel_out,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [10:0]    wr_x,
  input  logic [10:0]    wr_y,
  input  logic [BPP-1:0] wr_pixel,
  output logic           wr_oob,
  input  logic           clear_req,
  input  logic [BPP-1:0] clear_colour,
  output logic           busy,
  output logic           clear_done
);

  localparam int DEPTH = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
  localparam logic [10:0] H_END = 11'(H_ACTIVE - 1);

  if (!bpp_legal(BPP) || ((2 ** ADDR_W) < DEPTH)) begin : g_bad_cfg
    $error("vga_frame_buffer: illegal BPP or ADDR_W");
  end

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [BPP-1:0]    colour_q, colour_d;
  logic              done_q, done_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BPP-1:0]    wr_data_q, wr_data_d;
  logic              oob_q, oob_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [LATENCY-2:0] act_q, act_d;
  logic [23:0]       pix_q, pix_d;

  logic              accept;
  logic              in_range;
  logic [ADDR_W-1:0] base_cur;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [BPP-1:0]    ram_wdata;
  logic [BPP-1:0]    ram_rdata;

  assign wr_ready   = (state_q == ST_IDLE) && !clear_req;
  assign accept     = wr_valid && wr_ready;
  assign in_range   = (wr_x < H_LIM) && (wr_y < V_LIM);
  assign wr_oob     = oob_q;
  assign busy       = (state_q == ST_CLEAR);
  assign clear_done = done_q;
  assign pixel_out  = pix_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    colour_d  = colour_q;
    done_d    = 1'b0;
    wr_pend_d = accept && in_range;
    oob_d     = accept && !in_range;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ram_we    = 1'b0;
    ram_waddr = wr_addr_q;
    ram_wdata = wr_data_q;
    if (accept) begin
      wr_addr_d = ADDR_W'(wr_y) * H_STEP + ADDR_W'(wr_x);
      wr_data_d = wr_pixel;
    end
    // A pending write always lands in IDLE: accepts never precede CLEAR.
    unique case (state_q)
      ST_IDLE: begin
        ram_we = wr_pend_q;
        if (clear_req) begin
          state_d  = ST_CLEAR;
          cnt_d    = '0;
          colour_d = clear_colour;
        end
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = colour_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    base_cur   = ((vga_h == '0) && (vga_v == '0)) ? '0 : row_base_q;
    rd_addr_d  = base_cur + ADDR_W'(vga_h);
    row_base_d = base_cur;
    if ((vga_h == H_END) && (vga_v < V_LIM)) begin
      row_base_d = base_cur + H_STEP;
    end
    act_d = {act_q[LATENCY-3:0], (vga_h < H_LIM) && (vga_v < V_LIM)};
    if (ovl_on) begin
      pix_d = expand_rgb(24'(ovl_pixel), BPP);
    end else if (act_q[LATENCY-2]) begin
      pix_d = expand_rgb(24'(ram_rdata), BPP);
    end else begin
      pix_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      colour_q   <= '0;
      done_q     <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      oob_q      <= 1'b0;
      row_base_q <= '0;
      rd_addr_q  <= '0;
      act_q      <= '0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      colour_q   <= colour_d;
      done_q     <= done_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      oob_q      <= oob_d;
      row_base_q <= row_base_d;
      rd_addr_q  <= rd_addr_d;
      act_q      <= act_d;
      pix_q      <= pix_d;
    end
  end

  vga_fb_ram #(
    .WIDTH  (BPP),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Directed bench for vga_frame_buffer (8x4 frame, BPP 3 and 6).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_vga_frame_buffer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] vga_h = '0, vga_v = '0;
  logic [10:0] wr_x = '0, wr_y = '0;
  logic        ovl_on = 1'b0;
  logic [2:0]  ovl_pixel = '0, wr_pixel = '0, clear_colour = '0;
  logic        wr_valid = 1'b0, clear_req = 1'b0;
  logic [23:0] pixel_out;
  logic        wr_ready, wr_oob, busy, clear_done;

  logic        w6_valid = 1'b0;
  logic [5:0]  w6_pixel = '0;
  logic        zero1 = 1'b0;
  logic [5:0]  zero6 = '0;
  logic [23:0] px6;
  logic        w6_ready, w6_oob, busy6, done6;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] m [32];

  vga_frame_buffer #(
    .H_ACTIVE(8), .V_ACTIVE(4), .BPP(3), .ADDR_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_h(vga_h), .vga_v(vga_v),
    .ovl_on(ovl_on), .ovl_pixel(ovl_pixel),
    .pixel_out(pixel_out),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .wr_oob(wr_oob),
    .clear_req(clear_req), .clear_colour(clear_colour),
    .busy(busy), .clear_done(clear_done)
  );

  vga_frame_buffer #(
    .H_ACTIVE(8), .V_ACTIVE(4), .BPP(6), .ADDR_W(5)
  ) dut6 (
    .clk(clk), .rst_n(rst_n),
    .vga_h(vga_h), .vga_v(vga_v),
    .ovl_on(zero1), .ovl_pixel(zero6),
    .pixel_out(px6),
    .wr_valid(w6_valid), .wr_ready(w6_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(w6_pixel),
    .wr_oob(w6_oob),
    .clear_req(zero1), .clear_colour(zero6),
    .busy(busy6), .clear_done(done6)
  );

  task automatic chk(input string tag,
                     input logic [23:0] obs,
                     input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_ovl(input bit wo, input int h, input int v);
    return wo && (((h == 5) && (v == 1)) || ((h == 10) && (v == 6)));
  endfunction

  function automatic logic [23:0] exp_px(input bit wo,
                                         input int h, input int v);
    logic [2:0] p;
    if (is_ovl(wo, h, v)) return 24'h0000FF;
    if ((h < 8) && (v < 4)) begin
      p = m[v*8+h];
      return {{8{p[2]}}, {8{p[1]}}, {8{p[0]}}};
    end
    return 24'h000000;
  endfunction

  // Streams h 0..10, v 0..6; overlay for step j is driven 2 cycles later.
  task automatic scan(input string tag, input bit wo);
    int hs[$];
    int vs[$];
    int n;
    for (int v = 0; v < 7; v++)
      for (int h = 0; h < 11; h++) begin
        hs.push_back(h);
        vs.push_back(v);
      end
    n = hs.size();
    for (int k = 0; k < n + 3; k++) begin
      @(negedge clk);
      if (k >= 3)
        chk($sformatf("%s(%0d,%0d)", tag, hs[k-3], vs[k-3]),
            pixel_out, exp_px(wo, hs[k-3], vs[k-3]));
      if (k < n) begin
        vga_h = 11'(hs[k]);
        vga_v = 11'(vs[k]);
      end else begin
        vga_h = '0;
        vga_v = '0;
      end
      ovl_on    = 1'b0;
      ovl_pixel = '0;
      if ((k >= 2) && (k - 2 < n) && is_ovl(wo, hs[k-2], vs[k-2])) begin
        ovl_on    = 1'b1;
        ovl_pixel = 3'b001;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo, bz, dn;
    #1;
    chk("rst_pixel", pixel_out, 24'h0);
    chk("rst_busy", 24'(busy), 24'h0);
    chk("rst_done", 24'(clear_done), 24'h0);
    chk("rst_oob", 24'(wr_oob), 24'h0);
    chk("rst_ready", 24'(wr_ready), 24'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    w6_valid = 1'b1; wr_x = 0; wr_y = 0; w6_pixel = 6'b11_01_10;
    @(negedge clk);
    w6_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bpp6_px", px6, 24'hFF55AA);

    @(negedge clk);
    clear_colour = 3'b100; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clear_done) break;
    end
    chk("init_done", 24'(clear_done), 24'h1);
    for (int i = 0; i < 32; i++) m[i] = 3'b100;
    scan("init", 1'b0);

    @(negedge clk);
    wr_valid = 1'b1; wr_x = 3; wr_y = 2; wr_pixel = 3'b101;
    #1 chk("wr_ready", 24'(wr_ready), 24'h1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr_no_oob", 24'(wr_oob), 24'h0);
    m[19] = 3'b101;
    scan("wr", 1'b0);

    @(negedge clk);
    wr_valid = 1'b1; wr_x = 8; wr_y = 0; wr_pixel = 3'b111;
    #1 chk("oob_ready", 24'(wr_ready), 24'h1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("oob_pulse", 24'(wr_oob), 24'h1);
    @(negedge clk);
    chk("oob_end", 24'(wr_oob), 24'h0);
    scan("oob", 1'b0);

    @(negedge clk);
    clear_colour = 3'b010; clear_req = 1'b1;
    wr_valid = 1'b1; wr_x = 1; wr_y = 1; wr_pixel = 3'b111;
    lo = 0; bz = 0; dn = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (!wr_ready) lo++;
      if (busy) bz++;
      if (clear_done) dn++;
      if (wr_ready) break;
      @(negedge clk);
      clear_req = 1'b0;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("clr_done_end", 24'(clear_done), 24'h0);
    chk("clr_ready_lo", 24'(lo), 24'd33);
    chk("clr_busy_cyc", 24'(bz), 24'd32);
    chk("clr_done_cnt", 24'(dn), 24'd1);
    for (int i = 0; i < 32; i++) m[i] = 3'b010;
    m[9] = 3'b111;
    scan("clr", 1'b0);

    scan("ovl", 1'b1);

    @(negedge clk);
    clear_colour = 3'b011; clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", 24'(busy), 24'h1);
    chk("mid_px", pixel_out, 24'h00FFFF);
    rst_n = 1'b0;
    #1;
    chk("arst_px", pixel_out, 24'h0);
    chk("arst_busy", 24'(busy), 24'h0);
    chk("arst_done", 24'(clear_done), 24'h0);
    chk("arst_ready", 24'(wr_ready), 24'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0; bz = 0;
    repeat (40) begin
      @(negedge clk);
      if (clear_done) dn++;
      if (busy) bz++;
    end
    chk("arst_no_done", 24'(dn), 24'd0);
    chk("arst_idle", 24'(bz), 24'd0);
    for (int i = 0; i < 9; i++) m[i] = 3'b011;
    scan("part", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
